// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: instruction layout, FSM states
// and the ALU function codes understood by the downstream datapath.
package alu_op_sequencer_pkg;

    localparam int INSTR_W    = 14;
    localparam int LAST_BIT   = 13;
    localparam int ALUSEL_MSB = 12;
    localparam int ALUSEL_LSB = 10;
    localparam int SELA_BIT   = 9;
    localparam int SELB_BIT   = 8;
    localparam int OPA_MSB    = 7;
    localparam int OPA_LSB    = 4;
    localparam int OPB_MSB    = 3;
    localparam int OPB_LSB    = 0;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_NOT    = 3'd5;
    localparam logic [2:0] ALU_PASS_A = 3'd6;
    localparam logic [2:0] ALU_PASS_B = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic       last;
        logic [2:0] alu_sel;
        logic       sel_a;
        logic       sel_b;
        logic [3:0] op_a;
        logic [3:0] op_b;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
        instr_t i;
        i.last    = w[LAST_BIT];
        i.alu_sel = w[ALUSEL_MSB:ALUSEL_LSB];
        i.sel_a   = w[SELA_BIT];
        i.sel_b   = w[SELB_BIT];
        i.op_a    = w[OPA_MSB:OPA_LSB];
        i.op_b    = w[OPB_MSB:OPB_LSB];
        return i;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_op_fifo.sv
// Circular instruction buffer with occupancy count; push and pop are ignored
// when full or empty respectively.
module op_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues buffered ALU micro-instructions to the datapath one at a time,
// spaced by the datapath pipeline latency, and reports completion.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DP_LATENCY = 3,
    parameter int IW         = INSTR_W
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_data,
    output logic          wr_full,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [3:0]    issued,
    output logic [3:0]    Operand_A,
    output logic [3:0]    Operand_B,
    output logic          Sel_A,
    output logic          Sel_B,
    output logic [2:0]    ALU_SEL,
    output logic          dp_load
);

    localparam int CW = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [3:0]    issued_q, issued_d, issued_base;
    logic [3:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic          sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [2:0]    alu_sel_q, alu_sel_d;
    logic          dp_load_q, dp_load_d;

    logic          fifo_pop, fifo_empty;
    logic [IW-1:0] fifo_head;
    instr_t        head_i;
    logic          issue_now, decide_now, finish_now;

    op_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
        .clk       (CLK),
        .rst       (Reset),
        .push      (wr_en && !busy_q),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (wr_full),
        .empty     (fifo_empty)
    );

    assign head_i = decode_instr(fifo_head);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        issued_d    = issued_q;
        issued_base = issued_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        alu_sel_d   = alu_sel_q;
        dp_load_d   = 1'b0;
        fifo_pop    = 1'b0;
        issue_now   = 1'b0;
        decide_now  = 1'b0;
        finish_now  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !fifo_empty) begin
                    issue_now   = 1'b1;
                    err_d       = 1'b0;
                    issued_base = '0;
                end
            end
            S_ISSUE: begin
                if (DP_LATENCY == 1) begin
                    decide_now = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(DP_LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q <= CW'(1)) decide_now = 1'b1;
                else                 cnt_d = cnt_q - CW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // End of a latency window: finish on last, issue the next entry, or flag underrun.
        if (decide_now) begin
            if (last_q) begin
                finish_now = 1'b1;
            end else if (!fifo_empty) begin
                issue_now = 1'b1;
            end else begin
                err_d      = 1'b1;
                finish_now = 1'b1;
            end
        end

        // Outputs are loaded on entry to ISSUE so dp_load is high during the ISSUE cycle.
        if (issue_now) begin
            state_d   = S_ISSUE;
            busy_d    = 1'b1;
            dp_load_d = 1'b1;
            fifo_pop  = 1'b1;
            last_d    = head_i.last;
            op_a_d    = head_i.op_a;
            op_b_d    = head_i.op_b;
            sel_a_d   = head_i.sel_a;
            sel_b_d   = head_i.sel_b;
            alu_sel_d = head_i.alu_sel;
            issued_d  = (issued_base == 4'hF) ? 4'hF : issued_base + 4'd1;
        end

        if (finish_now) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            issued_q  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sel_a_q   <= 1'b0;
            sel_b_q   <= 1'b0;
            alu_sel_q <= '0;
            dp_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            issued_q  <= issued_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            alu_sel_q <= alu_sel_d;
            dp_load_q <= dp_load_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign issued    = issued_q;
    assign Operand_A = op_a_q;
    assign Operand_B = op_b_q;
    assign Sel_A     = sel_a_q;
    assign Sel_B     = sel_b_q;
    assign ALU_SEL   = alu_sel_q;
    assign dp_load   = dp_load_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: a queue-based model predicts which entries each start
// issues, at which cycles dp_load/done appear, and the final issued/err values.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int DEPTH = 8;
    localparam int L     = 3;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        wr_en;
    logic [13:0] wr_data;
    logic        wr_full;
    logic        start;
    logic        busy, done, err, dp_load;
    logic [3:0]  issued, Operand_A, Operand_B;
    logic        Sel_A, Sel_B;
    logic [2:0]  ALU_SEL;

    int n_checks = 0;
    int n_fail   = 0;
    instr_t q[$];

    alu_op_sequencer #(.DEPTH(DEPTH), .DP_LATENCY(L)) dut (
        .CLK(CLK), .Reset(Reset), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .start(start), .busy(busy), .done(done),
        .err(err), .issued(issued), .Operand_A(Operand_A),
        .Operand_B(Operand_B), .Sel_A(Sel_A), .Sel_B(Sel_B),
        .ALU_SEL(ALU_SEL), .dp_load(dp_load)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t mk(bit last, logic [2:0] sel, bit sa, bit sb,
                                  logic [3:0] a, logic [3:0] b);
        instr_t i;
        i.last = last; i.alu_sel = sel; i.sel_a = sa; i.sel_b = sb;
        i.op_a = a; i.op_b = b;
        return i;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_issued"}, issued, 0);
        check({tag, "_opa"}, Operand_A, 0);
        check({tag, "_opb"}, Operand_B, 0);
        check({tag, "_sela"}, Sel_A, 0);
        check({tag, "_selb"}, Sel_B, 0);
        check({tag, "_alusel"}, ALU_SEL, 0);
        check({tag, "_dpload"}, dp_load, 0);
        check({tag, "_full"}, wr_full, 0);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic push_instr(input instr_t i);
        wr_en = 1'b1;
        wr_data = i;
        @(negedge CLK);
        wr_en = 1'b0;
        if (q.size() < DEPTH) q.push_back(i);
        check("wr_full", wr_full, q.size() == DEPTH);
    endtask

    task automatic run_start(input bit noise);
        instr_t exp[$];
        int     n, last_c, k;
        bit     exp_err, exp_dp;
        while (q.size() > 0) begin
            exp.push_back(q.pop_front());
            if (exp[exp.size()-1].last) break;
        end
        n = exp.size();
        start = 1'b1;
        if (n == 0) begin
            for (int c = 1; c <= L + 2; c++) begin
                @(negedge CLK);
                start = 1'b0;
                check("idle_busy", busy, 0);
                check("idle_dpload", dp_load, 0);
                check("idle_done", done, 0);
            end
            return;
        end
        exp_err = !exp[n-1].last;
        last_c  = 1 + n * L;
        for (int c = 1; c <= last_c + 1; c++) begin
            @(negedge CLK);
            start = 1'b0;
            wr_en = 1'b0;
            if (noise && c <= n * L) begin
                wr_en   = 1'($urandom);
                wr_data = 14'($urandom);
                start   = 1'($urandom);
            end
            k      = (c - 1) / L;
            exp_dp = ((c - 1) % L == 0) && (k < n);
            if (k > n - 1) k = n - 1;
            check("dp_load", dp_load, exp_dp);
            check("done", done, c == last_c);
            check("busy", busy, c < last_c);
            check("Operand_A", Operand_A, exp[k].op_a);
            check("Operand_B", Operand_B, exp[k].op_b);
            check("Sel_A", Sel_A, exp[k].sel_a);
            check("Sel_B", Sel_B, exp[k].sel_b);
            check("ALU_SEL", ALU_SEL, exp[k].alu_sel);
            if (c == 1) begin
                check("err_cleared", err, 0);
                check("issued_first", issued, 1);
            end
        end
        wr_en = 1'b0;
        check("issued_end", issued, (n > 15) ? 15 : n);
        check("err_end", err, exp_err);
        check("full_end", wr_full, q.size() == DEPTH);
    endtask

    initial begin
        Reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        // Abort mid-WAIT with an asynchronous reset.
        push_instr(mk(0, ALU_SUB, 1, 1, 4'h9, 4'h6));
        push_instr(mk(0, ALU_OR, 1, 0, 4'hA, 4'h1));
        push_instr(mk(1, ALU_XOR, 0, 1, 4'h7, 4'hC));
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_opa", Operand_A, 4'h9);
        #2 Reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge CLK);
        Reset = 1'b0;
        q.delete();
        run_start(0);

        // Two-instruction program.
        push_instr(mk(0, ALU_ADD, 1, 1, 4'd3, 4'd5));
        push_instr(mk(1, ALU_ADD, 0, 1, 4'd0, 4'd2));
        run_start(0);

        // Fill to full; ninth write dropped.
        for (int i = 0; i < 9; i++)
            push_instr(mk(i == 7, 3'(i), i[0], i[1], 4'(i + 1), 4'(15 - i)));
        run_start(0);
        run_start(0);

        // Underrun: no last bit.
        push_instr(mk(0, ALU_AND, 1, 1, 4'd1, 4'd2));
        push_instr(mk(0, ALU_NOT, 0, 0, 4'd3, 4'd4));
        run_start(0);

        // Entries after a last stay for the next start; noise while busy.
        push_instr(mk(1, ALU_PASS_A, 1, 0, 4'd5, 4'd6));
        push_instr(mk(0, ALU_PASS_B, 0, 1, 4'd7, 4'd8));
        push_instr(mk(0, ALU_SUB, 1, 1, 4'd9, 4'd10));
        run_start(1);
        run_start(1);

        for (int it = 0; it < 12; it++) begin
            int m = $urandom_range(0, 5);
            for (int j = 0; j < m; j++) begin
                instr_t r = instr_t'(14'($urandom));
                r.last = ($urandom_range(0, 2) == 0);
                push_instr(r);
            end
            run_start(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream control stage for the 4-bit register/ALU/accumulator datapath.
- Buffers a short program of ALU micro-instructions written by a host.
- On start, issues the instructions one at a time on the datapath control pins (operands, mux selects, ALU select, load strobe).
- Spaces issues by the datapath's fixed pipeline latency, then signals completion.

Parameters:
DEPTH, 8, instruction buffer entries; power of two, minimum 2.
DP_LATENCY, 3, cycles from a load strobe to a valid datapath Result; minimum 1.
IW, 14, instruction width; fixed layout, not intended for override.

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
wr_en  input  1  host write strobe for the instruction buffer
wr_data  input  14  instruction: [13]=last, [12:10]=alu_sel, [9]=sel_a, [8]=sel_b, [7:4]=op_a, [3:0]=op_b
wr_full  output  1  buffer full
start  input  1  begin executing the buffered program
busy  output  1  program executing
done  output  1  one-cycle pulse when the program completes
err  output  1  sticky: buffer emptied before an instruction with last=1 was issued
issued  output  4  count of instructions issued in the current or last run; saturates at 15
Operand_A  output  4  datapath operand A
Operand_B  output  4  datapath operand B
Sel_A  output  1  mux select A (1=operand, 0=accumulator feedback)
Sel_B  output  1  mux select B
ALU_SEL  output  3  ALU function select
dp_load  output  1  datapath register load enable; one-cycle pulse per instruction

Behaviour:
- Reset (async, active-high):
  - Buffer empties: read/write pointers and count go to 0.
  - State goes to IDLE.
  - All outputs go to 0; wr_full reflects count, so it is 0.
  - Reset mid-run aborts the run; no done pulse is generated.
- Buffer:
  - Circular; pointers wrap modulo DEPTH; count runs 0..DEPTH.
  - wr_full = (count==DEPTH).
  - A write is accepted only when wr_en=1, wr_full=0 and busy=0; otherwise it is silently dropped.
  - The buffer is never written while busy, so a read and a write never coincide.
- States:
  - IDLE:
    - If start=1 and count>0: clear err, clear issued, go to ISSUE, assert busy.
    - start with count==0 is ignored; start while busy is ignored.
  - ISSUE, one cycle:
    - Registered control outputs load the fields of the head entry.
    - dp_load=1 for this cycle; pop the head; issued++.
    - Capture the last bit; go to WAIT with wait counter = DP_LATENCY-1.
  - WAIT:
    - dp_load=0; Operand/Sel/ALU_SEL hold their issued values.
    - The counter decrements; at 0:
      - if captured last=1, go to DONE;
      - else if count>0, go to ISSUE;
      - else set err=1 and go to DONE.
  - DONE, one cycle: done=1, busy=0 next, then IDLE.
- Outputs:
  - All control outputs are registered; no combinational path from inputs.
  - Controls keep their last values in IDLE.
- Throughput: one instruction per DP_LATENCY cycles.
- Latency: first dp_load occurs 1 cycle after start is sampled. done occurs DP_LATENCY cycles after the last dp_load.
- Entries beyond a last=1 instruction stay buffered for the next start.
- issued saturates at 15 and does not wrap.

Decomposition:
- Shared package:
  - instruction field bit positions (LAST_BIT, ALUSEL_MSB/LSB, SELA_BIT, SELB_BIT, OPA/OPB ranges);
  - state encoding (IDLE, ISSUE, WAIT, DONE);
  - the ALU_SEL opcode constants used by the ALU.
- One sub-module, op_fifo: circular buffer with count, full/empty, push/pop. The top-level holds the FSM and wait counter.

Test Plan:
- Reset asserted mid-WAIT of a 3-instruction run -> all outputs 0 immediately (asynchronously); no done pulse; buffer empty; following start ignored.
- Write 2 instrs {last=0, sel=ADD, A=3, B=5, Sel_A=Sel_B=1}, {last=1, Sel_A=0, Sel_B=1, B=2}, then start; DP_LATENCY=3 ->
  - dp_load high at cycles 1 and 4 after start;
  - Operand_A=3, Operand_B=5 during 1–3;
  - done pulse at cycle 7; issued=2; err=0.
- Write 8 entries -> wr_full=1; 9th write dropped. Run with last bit only on entry 8 -> issued=8, err=0, buffer empty.
- Program of 2 entries, both last=0 -> after second WAIT: err=1, done pulses, issued=2, busy drops.
- Write 3 entries with last=1 on entry 1; start twice -> first run issued=1; second run issues entries 2–3 (then err=1). start and wr_en pulsed during busy -> no effect on count or state.
